branch_predictor: RTL and testbench

Dynamic branch predictor and misprediction resolver for the 5-stage pipeline. It looks up a direct-mapped branch target buffer (BTB) with 2-bit saturating counters in Fetch to supply a predicted next PC. It resolves the prediction in Execute and produces `flushBranch`, the branch-misprediction flush consumed by the hazard unit, together with the recovery PC. It also keeps saturating performance counters for branches and mispredictions.

---
 rtl/branch_predictor_if.sv | 30 +++
 rtl/branch_predictor.sv | 130 +++++++++++++
 tb/tb_branch_predictor.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch lookup and Execute resolution signals between the pipeline and the branch predictor.
// The pipeline drives through the master modport; the predictor uses the slave modport.
interface branch_predictor_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic [ADDR_WIDTH-1:0] PCF;
  logic                  PredTakenF;
  logic [ADDR_WIDTH-1:0] PredTargetF;
  logic                  BranchE;
  logic [ADDR_WIDTH-1:0] PCE;
  logic                  PredTakenE;
  logic [ADDR_WIDTH-1:0] PredTargetE;
  logic                  ActualTakenE;
  logic [ADDR_WIDTH-1:0] ActualTargetE;
  logic                  flushBranch;
  logic [ADDR_WIDTH-1:0] RecoverPCE;
  logic [CNT_WIDTH-1:0]  BranchCount;
  logic [CNT_WIDTH-1:0]  MispredCount;

  modport master (
    output PCF, BranchE, PCE, PredTakenE, PredTargetE, ActualTakenE, ActualTargetE,
    input  PredTakenF, PredTargetF, flushBranch, RecoverPCE, BranchCount, MispredCount
  );

  modport slave (
    input  PCF, BranchE, PCE, PredTakenE, PredTargetE, ActualTakenE, ActualTargetE,
    output PredTakenF, PredTargetF, flushBranch, RecoverPCE, BranchCount, MispredCount
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational Fetch lookup,
// Execute misprediction resolve/recovery, and saturating branch/mispredict counters.
module branch_predictor #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 4,
  parameter int CNT_WIDTH  = 32
) (
  input logic               clk,
  input logic               rst_n,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = ADDR_WIDTH - INDEX_BITS - 2;

  logic                  valid_r  [ENTRIES];
  logic [1:0]            ctr_r    [ENTRIES];
  logic [TAG_W-1:0]      tag_r    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_r [ENTRIES];
  logic [CNT_WIDTH-1:0]  branch_cnt_r;
  logic [CNT_WIDTH-1:0]  mispred_cnt_r;

  logic [INDEX_BITS-1:0] idx_f_s;
  logic [TAG_W-1:0]      tag_f_s;
  logic                  hit_f_s;
  logic [INDEX_BITS-1:0] idx_e_s;
  logic [TAG_W-1:0]      tag_e_s;
  logic                  hit_e_s;
  logic                  mispredict_s;
  logic                  flush_s;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    if (c == 2'b11) return 2'b11;
    else            return c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    if (c == 2'b00) return 2'b00;
    else            return c - 2'b01;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] cnt_sat_inc(input logic [CNT_WIDTH-1:0] c);
    if (&c) return c;
    else    return c + CNT_WIDTH'(32'd1);
  endfunction

  // Fetch lookup: predicted direction and next PC straight from the BTB, no bypass.
  always_comb begin
    idx_f_s = bp.PCF[INDEX_BITS+1:2];
    tag_f_s = bp.PCF[ADDR_WIDTH-1:INDEX_BITS+2];
    hit_f_s = valid_r[idx_f_s] && (tag_r[idx_f_s] == tag_f_s);
    if (hit_f_s && ctr_r[idx_f_s][1]) begin
      bp.PredTakenF  = 1'b1;
      bp.PredTargetF = target_r[idx_f_s];
    end else begin
      bp.PredTakenF  = 1'b0;
      bp.PredTargetF = bp.PCF + ADDR_WIDTH'(32'd4);
    end
  end

  // Execute resolution: compare the carried prediction with the actual outcome.
  always_comb begin
    idx_e_s      = bp.PCE[INDEX_BITS+1:2];
    tag_e_s      = bp.PCE[ADDR_WIDTH-1:INDEX_BITS+2];
    hit_e_s      = valid_r[idx_e_s] && (tag_r[idx_e_s] == tag_e_s);
    mispredict_s = (bp.ActualTakenE != bp.PredTakenE) ||
                   (bp.ActualTakenE && (bp.ActualTargetE != bp.PredTargetE));
    // Reset gates the flush directly so it drops the moment rst_n falls.
    flush_s      = rst_n && bp.BranchE && mispredict_s;
    if (bp.ActualTakenE) begin
      bp.RecoverPCE = bp.ActualTargetE;
    end else begin
      bp.RecoverPCE = bp.PCE + ADDR_WIDTH'(32'd4);
    end
  end

  // Drive the flush and performance counter outputs.
  always_comb begin
    bp.flushBranch  = flush_s;
    bp.BranchCount  = branch_cnt_r;
    bp.MispredCount = mispred_cnt_r;
  end

  // BTB training on resolved branches; misses allocate only when taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        ctr_r[i]    <= 2'b01;
        tag_r[i]    <= '0;
        target_r[i] <= '0;
      end
    end else if (bp.BranchE) begin
      if (hit_e_s) begin
        if (bp.ActualTakenE) begin
          ctr_r[idx_e_s]    <= ctr_inc(ctr_r[idx_e_s]);
          target_r[idx_e_s] <= bp.ActualTargetE;
        end else begin
          ctr_r[idx_e_s]    <= ctr_dec(ctr_r[idx_e_s]);
        end
      end else if (bp.ActualTakenE) begin
        valid_r[idx_e_s]  <= 1'b1;
        tag_r[idx_e_s]    <= tag_e_s;
        target_r[idx_e_s] <= bp.ActualTargetE;
        ctr_r[idx_e_s]    <= 2'b10;
      end else begin
        valid_r[idx_e_s]  <= valid_r[idx_e_s];
      end
    end else begin
      valid_r[idx_e_s] <= valid_r[idx_e_s];
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_r  <= '0;
      mispred_cnt_r <= '0;
    end else if (bp.BranchE) begin
      branch_cnt_r <= cnt_sat_inc(branch_cnt_r);
      if (flush_s) begin
        mispred_cnt_r <= cnt_sat_inc(mispred_cnt_r);
      end else begin
        mispred_cnt_r <= mispred_cnt_r;
      end
    end else begin
      branch_cnt_r  <= branch_cnt_r;
      mispred_cnt_r <= mispred_cnt_r;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: BTB training, hysteresis, target updates,
// aliasing, bubbles and asynchronous reset, with hand-computed expectations.
module tb_branch_predictor;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  branch_predictor_if #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) bp ();

  branch_predictor #(.ADDR_WIDTH(32), .INDEX_BITS(4), .CNT_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_taken,
                        input logic [31:0] exp_tgt);
    bp.PCF = pc;
    #1;
    check_val({tag, "_taken"}, 64'(bp.PredTakenF), 64'(exp_taken));
    check_val({tag, "_target"}, 64'(bp.PredTargetF), 64'(exp_tgt));
  endtask

  task automatic counts(input string tag, input int exp_b, input int exp_m);
    check_val({tag, "_branch_cnt"}, 64'(bp.BranchCount), 64'(exp_b));
    check_val({tag, "_mispred_cnt"}, 64'(bp.MispredCount), 64'(exp_m));
  endtask

  // One resolved branch; also checks the same-cycle lookup of PCE sees the old prediction.
  task automatic resolve(input string tag, input logic [31:0] pce, input logic pt,
                         input logic [31:0] ptgt, input logic at, input logic [31:0] atgt,
                         input logic exp_flush, input logic [31:0] exp_rec);
    @(negedge clk);
    bp.BranchE       = 1'b1;
    bp.PCE           = pce;
    bp.PCF           = pce;
    bp.PredTakenE    = pt;
    bp.PredTargetE   = ptgt;
    bp.ActualTakenE  = at;
    bp.ActualTargetE = atgt;
    #1;
    check_val({tag, "_flush"}, 64'(bp.flushBranch), 64'(exp_flush));
    if (exp_flush) check_val({tag, "_recover"}, 64'(bp.RecoverPCE), 64'(exp_rec));
    else           check_val({tag, "_recover"}, 64'(bp.RecoverPCE), 64'(exp_rec));
    check_val({tag, "_old_pred"}, 64'(bp.PredTakenF), 64'(pt));
    @(negedge clk);
    bp.BranchE = 1'b0;
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst_n            = 1'b0;
    bp.PCF           = 32'h100;
    bp.BranchE       = 1'b0;
    bp.PCE           = 32'h0;
    bp.PredTakenE    = 1'b0;
    bp.PredTargetE   = 32'h0;
    bp.ActualTakenE  = 1'b0;
    bp.ActualTargetE = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    lookup("post_reset", 32'h100, 1'b0, 32'h104);
    counts("post_reset", 0, 0);
    check_val("post_reset_flush", 64'(bp.flushBranch), 64'd0);

    resolve("cold_taken", 32'h100, 1'b0, 32'h104, 1'b1, 32'h200, 1'b1, 32'h200);
    lookup("cold_after", 32'h100, 1'b1, 32'h200);
    counts("cold_after", 1, 1);

    resolve("hyst_nt", 32'h100, 1'b1, 32'h200, 1'b0, 32'h200, 1'b1, 32'h104);
    lookup("hyst_after", 32'h100, 1'b0, 32'h104);
    resolve("retrain1", 32'h100, 1'b0, 32'h104, 1'b1, 32'h200, 1'b1, 32'h200);
    resolve("retrain2", 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h200);
    lookup("retrain_after", 32'h100, 1'b1, 32'h200);
    counts("retrain_after", 4, 3);

    resolve("tgt_mismatch", 32'h100, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1, 32'h300);
    lookup("tgt_after", 32'h100, 1'b1, 32'h300);

    resolve("nt1", 32'h100, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 32'h104);
    lookup("nt1_after", 32'h100, 1'b1, 32'h300);
    resolve("nt2", 32'h100, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 32'h104);
    lookup("nt2_after", 32'h100, 1'b0, 32'h104);
    resolve("nt3", 32'h100, 1'b0, 32'h104, 1'b0, 32'h0, 1'b0, 32'h104);
    resolve("nt4_sat", 32'h100, 1'b0, 32'h104, 1'b0, 32'h0, 1'b0, 32'h104);
    lookup("sat_low", 32'h100, 1'b0, 32'h104);
    resolve("up1", 32'h100, 1'b0, 32'h104, 1'b1, 32'h300, 1'b1, 32'h300);
    lookup("up1_after", 32'h100, 1'b0, 32'h104);
    resolve("up2", 32'h100, 1'b0, 32'h104, 1'b1, 32'h300, 1'b1, 32'h300);
    lookup("up2_after", 32'h100, 1'b1, 32'h300);
    counts("train_done", 11, 8);

    lookup("alias", 32'h140, 1'b0, 32'h144);
    resolve("alias_nt", 32'h140, 1'b0, 32'h144, 1'b0, 32'h0, 1'b0, 32'h144);
    lookup("alias_after", 32'h100, 1'b1, 32'h300);
    counts("alias_after", 12, 8);

    // Bubble: mismatching inputs with BranchE low.
    @(negedge clk);
    bp.BranchE       = 1'b0;
    bp.PCE           = 32'h100;
    bp.PredTakenE    = 1'b0;
    bp.ActualTakenE  = 1'b1;
    bp.ActualTargetE = 32'h500;
    #1;
    check_val("bubble_flush", 64'(bp.flushBranch), 64'd0);
    @(negedge clk);
    lookup("bubble_after", 32'h100, 1'b1, 32'h300);
    counts("bubble_after", 12, 8);
    lookup("pc_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    // Asynchronous reset mid-cycle with a pending mispredict.
    @(negedge clk);
    bp.BranchE       = 1'b1;
    bp.PCE           = 32'h180;
    bp.PCF           = 32'h100;
    bp.PredTakenE    = 1'b0;
    bp.PredTargetE   = 32'h184;
    bp.ActualTakenE  = 1'b1;
    bp.ActualTargetE = 32'h700;
    #1;
    check_val("pre_reset_flush", 64'(bp.flushBranch), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("reset_flush", 64'(bp.flushBranch), 64'd0);
    lookup("reset_lookup", 32'h100, 1'b0, 32'h104);
    counts("reset", 0, 0);
    @(negedge clk);
    bp.BranchE = 1'b0;
    rst_n      = 1'b1;
    lookup("reset_discard", 32'h180, 1'b0, 32'h184);
    lookup("reset_entry", 32'h100, 1'b0, 32'h104);
    counts("reset_after", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
